// File: rtl/move_msg_tx.sv
`default_nettype none
// ============================================================================
//  Module   : move_msg_tx
//  Purpose  : Serialises one connect-6 move (two stones, row/col each) into
//             an ASCII digit message and feeds it one byte at a time to the
//             UART byte transmitter through its tx_data / transmit_en /
//             transmit_done handshake. Runs in the baud_clk domain.
//  Ports    : baud_clk      - clock, all logic on the rising edge
//             reset         - asynchronous, active-low reset
//             move_valid    - engine presents a move
//             move_ready    - block can accept a move (IDLE only)
//             row1/col1     - stone 1 coordinates, legal 0..19
//             row2/col2     - stone 2 coordinates, legal 0..19
//             tx_data       - byte to the transmitter
//             transmit_en   - request to the transmitter
//             transmit_done - transmitter done flag
//             msg_done      - one-cycle pulse after the last byte's handshake
//             coord_err     - one-cycle pulse when a move is rejected
//             busy          - high whenever not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module move_msg_tx #(
  parameter bit         APPEND_NL = 1'b1,
  parameter logic [7:0] NL_CHAR   = 8'h0A
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [4:0] row1,
  input  logic [4:0] col1,
  input  logic [4:0] row2,
  input  logic [4:0] col2,
  output logic [7:0] tx_data,
  output logic       transmit_en,
  input  logic       transmit_done,
  output logic       msg_done,
  output logic       coord_err,
  output logic       busy
);

  localparam logic [3:0] C_LAST_IDX  = APPEND_NL ? 4'd8 : 4'd7;
  localparam logic [4:0] C_MAX_COORD = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_idx;
  logic [4:0] r_row1, r_col1, r_row2, r_col2;
  logic [7:0] r_tx_data;
  logic       r_msg_done;
  logic       r_coord_err;

  logic       w_coords_ok;
  logic       w_load_first;
  logic       w_advance;
  logic       w_finish;
  logic       w_reject;
  logic [3:0] w_idx_inc;

  // ASCII digit of a 0..19 value: tens is just the >=10 flag, ones is a
  // conditional subtract, so no divider is needed.
  function automatic logic [7:0] digit_byte(input logic [4:0] v, input logic tens);
    logic       ge10;
    logic [4:0] ones;
    ge10 = (v >= 5'd10);
    ones = ge10 ? (v - 5'd10) : v;
    if (tens) begin
      return 8'h30 + {7'd0, ge10};
    end
    return 8'h30 + {3'd0, ones};
  endfunction

  // Even indices carry the tens digit, odd indices the ones digit; pairs of
  // indices walk row1, col1, row2, col2. Index 8 is the terminator.
  function automatic logic [7:0] byte_at(input logic [3:0] idx,
                                         input logic [4:0] r1, input logic [4:0] c1,
                                         input logic [4:0] r2, input logic [4:0] c2);
    logic [7:0] b;
    case (idx[3:1])
      3'd0:    b = digit_byte(r1, ~idx[0]);
      3'd1:    b = digit_byte(c1, ~idx[0]);
      3'd2:    b = digit_byte(r2, ~idx[0]);
      3'd3:    b = digit_byte(c2, ~idx[0]);
      default: b = NL_CHAR;
    endcase
    return b;
  endfunction

  assign w_coords_ok = (row1 <= C_MAX_COORD) && (col1 <= C_MAX_COORD) &&
                       (row2 <= C_MAX_COORD) && (col2 <= C_MAX_COORD);
  assign w_idx_inc   = r_idx + 4'd1;

  // Next-state and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_load_first = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    w_reject     = 1'b0;
    transmit_en  = 1'b0;
    move_ready   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        move_ready = 1'b1;
        busy       = 1'b0;
        if (move_valid) begin
          if (w_coords_ok) begin
            w_state_nxt  = ST_SEND;
            w_load_first = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_SEND: begin
        transmit_en = 1'b1;
        if (transmit_done) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait for the transmitter to drop done so the next request never
        // rises on top of a stale done flag.
        if (!transmit_done) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = ST_SEND;
            w_advance   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 4'd0;
      r_row1      <= 5'd0;
      r_col1      <= 5'd0;
      r_row2      <= 5'd0;
      r_col2      <= 5'd0;
      r_tx_data   <= 8'h00;
      r_msg_done  <= 1'b0;
      r_coord_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_msg_done  <= w_finish;
      r_coord_err <= w_reject;
      if (w_load_first) begin
        r_row1    <= row1;
        r_col1    <= col1;
        r_row2    <= row2;
        r_col2    <= col2;
        r_idx     <= 4'd0;
        // First byte comes straight from the inputs so tx_data is valid in
        // the same cycle transmit_en first rises.
        r_tx_data <= digit_byte(row1, 1'b1);
      end else if (w_advance) begin
        r_idx     <= w_idx_inc;
        r_tx_data <= byte_at(w_idx_inc, r_row1, r_col1, r_row2, r_col2);
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign msg_done  = r_msg_done;
  assign coord_err = r_coord_err;

endmodule
`default_nettype wire

// File: tb/tb_move_msg_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_msg_tx
//  Purpose  : Directed self-checking bench for move_msg_tx. Two instances,
//             one with the terminator byte and one without, each driven by
//             a small transmitter model that records the bytes it receives.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_move_msg_tx;

  logic       baud_clk;
  logic       reset;
  logic [4:0] row1, col1, row2, col2;

  logic       a_mv, a_ready, a_en, a_md, a_ce, a_busy;
  logic [7:0] a_data;
  logic       b_mv, b_ready, b_en, b_md, b_ce, b_busy;
  logic [7:0] b_data;

  logic       done [2];
  int         cnt [2];
  int         hcnt [2];
  logic       prev_en [2];
  logic [7:0] prev_data [2];
  int         viol_rise [2];
  int         viol_hold [2];
  int         viol_both [2];
  int         md_cnt [2];
  int         ce_cnt [2];
  int         hold_extra;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int n_vec;
  int n_err;

  move_msg_tx #(.APPEND_NL(1'b1), .NL_CHAR(8'h0A)) dut_nl (
    .baud_clk(baud_clk), .reset(reset), .move_valid(a_mv), .move_ready(a_ready),
    .row1(row1), .col1(col1), .row2(row2), .col2(col2),
    .tx_data(a_data), .transmit_en(a_en), .transmit_done(done[0]),
    .msg_done(a_md), .coord_err(a_ce), .busy(a_busy)
  );

  move_msg_tx #(.APPEND_NL(1'b0), .NL_CHAR(8'h0A)) dut_nonl (
    .baud_clk(baud_clk), .reset(reset), .move_valid(b_mv), .move_ready(b_ready),
    .row1(row1), .col1(col1), .row2(row2), .col2(col2),
    .tx_data(b_data), .transmit_en(b_en), .transmit_done(done[1]),
    .msg_done(b_md), .coord_err(b_ce), .busy(b_busy)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  // Transmitter model plus protocol monitors, evaluated on the falling edge.
  always @(negedge baud_clk) begin
    for (int c = 0; c < 2; c++) begin
      logic       en;
      logic [7:0] dt;
      logic       md;
      logic       ce;
      en = (c == 0) ? a_en   : b_en;
      dt = (c == 0) ? a_data : b_data;
      md = (c == 0) ? a_md   : b_md;
      ce = (c == 0) ? a_ce   : b_ce;
      if (!reset) begin
        done[c]    = 1'b0;
        cnt[c]     = 0;
        hcnt[c]    = 0;
        prev_en[c] = 1'b0;
      end else begin
        if (en && !prev_en[c] && done[c]) viol_rise[c]++;
        if (en && prev_en[c] && (dt != prev_data[c])) viol_hold[c]++;
        if (md && ce) viol_both[c]++;
        if (md) md_cnt[c]++;
        if (ce) ce_cnt[c]++;
        if (!done[c]) begin
          if (en) begin
            cnt[c]++;
            if (cnt[c] >= 2) begin
              done[c] = 1'b1;
              cnt[c]  = 0;
              if (c == 0) q0.push_back(dt);
              else        q1.push_back(dt);
            end
          end
        end else if (!en) begin
          if (hcnt[c] >= hold_extra) begin
            done[c] = 1'b0;
            hcnt[c] = 0;
          end else begin
            hcnt[c]++;
          end
        end
        prev_en[c]   = en;
        prev_data[c] = dt;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_coords(input int r1, input int c1, input int r2, input int c2);
    row1 = 5'(r1); col1 = 5'(c1); row2 = 5'(r2); col2 = 5'(c2);
  endtask

  // Present one move for exactly one rising edge; returns at the next falling edge.
  task automatic send_move(input int ch, input int r1, input int c1, input int r2, input int c2);
    set_coords(r1, c1, r2, c2);
    if (ch == 0) a_mv = 1'b1; else b_mv = 1'b1;
    @(negedge baud_clk);
    a_mv = 1'b0;
    b_mv = 1'b0;
  endtask

  task automatic wait_msg(input int ch, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge baud_clk);
      if ((ch == 0) ? a_md : b_md) begin
        found = 1'b1;
        break;
      end
    end
    check_val({tag, " msg_done seen"}, 32'(found), 32'd1);
    check_val({tag, " busy at msg_done"}, 32'((ch == 0) ? a_busy : b_busy), 32'd0);
  endtask

  task automatic check_msg(input int ch, input int base, input int endsz,
                           input logic [71:0] exp, input int n, input string tag);
    logic [7:0] got;
    check_val({tag, " byte count"}, 32'(endsz - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < endsz) got = (ch == 0) ? q0[base + i] : q1[base + i];
      else                  got = 8'hFF;
      check_val($sformatf("%s byte %0d", tag, i), 32'(got), 32'(exp[8*(n-1-i) +: 8]));
    end
  endtask

  initial begin
    int base;
    int base2;
    bit found;
    n_vec = 0;
    n_err = 0;
    hold_extra = 0;
    for (int c = 0; c < 2; c++) begin
      viol_rise[c] = 0; viol_hold[c] = 0; viol_both[c] = 0;
      md_cnt[c] = 0; ce_cnt[c] = 0;
    end
    a_mv = 1'b0;
    b_mv = 1'b0;
    set_coords(0, 0, 0, 0);
    reset = 1'b0;

    // Reset values
    repeat (2) @(negedge baud_clk);
    check_val("rst move_ready", 32'(a_ready), 32'd1);
    check_val("rst busy",       32'(a_busy),  32'd0);
    check_val("rst tx_data",    32'(a_data),  32'h00);
    check_val("rst transmit_en", 32'(a_en),   32'd0);
    check_val("rst msg_done",   32'(a_md),    32'd0);
    check_val("rst coord_err",  32'(a_ce),    32'd0);
    reset = 1'b1;
    @(negedge baud_clk);

    // Move (3,15,10,19) with terminator
    base = q0.size();
    send_move(0, 3, 15, 10, 19);
    check_val("m1 en latency", 32'(a_en), 32'd1);
    check_val("m1 first byte", 32'(a_data), 32'h30);
    set_coords(7, 7, 7, 7);
    wait_msg(0, "m1");
    check_msg(0, base, q0.size(), 72'h30_33_31_35_31_30_31_39_0A, 9, "m1");
    @(negedge baud_clk);
    check_val("m1 busy after", 32'(a_busy), 32'd0);

    // Move (0,0,19,9) without terminator
    base = q1.size();
    send_move(1, 0, 0, 19, 9);
    wait_msg(1, "m2");
    check_msg(1, base, q1.size(), {8'h00, 64'h30_30_30_30_31_39_30_39}, 8, "m2");

    // Out-of-range move rejected, then a legal move goes through
    base = q0.size();
    send_move(0, 20, 1, 1, 1);
    check_val("rej coord_err", 32'(a_ce),    32'd1);
    check_val("rej en",        32'(a_en),    32'd0);
    check_val("rej ready",     32'(a_ready), 32'd1);
    @(negedge baud_clk);
    check_val("rej coord_err pulse", 32'(a_ce), 32'd0);
    check_val("rej en later",  32'(a_en),    32'd0);
    check_val("rej no bytes",  32'(q0.size() - base), 32'd0);
    send_move(0, 1, 1, 1, 1);
    wait_msg(0, "m3");
    check_msg(0, base, q0.size(), 72'h30_31_30_31_30_31_30_31_0A, 9, "m3");

    // Transmitter holding done high 5 extra cycles
    hold_extra = 5;
    @(negedge baud_clk);
    base = q0.size();
    send_move(0, 12, 7, 19, 0);
    wait_msg(0, "m4");
    check_msg(0, base, q0.size(), 72'h31_32_30_37_31_39_30_30_0A, 9, "m4");
    hold_extra = 0;
    repeat (8) @(negedge baud_clk);

    // move_valid held high with changing coordinates
    base = q0.size();
    set_coords(5, 6, 7, 8);
    a_mv = 1'b1;
    @(negedge baud_clk);
    check_val("m5 accepted", 32'(a_en), 32'd1);
    found = 1'b0;
    base2 = 0;
    for (int k = 0; k < 3000; k++) begin
      set_coords($urandom_range(0, 19), $urandom_range(0, 19),
                 $urandom_range(0, 19), $urandom_range(0, 19));
      @(negedge baud_clk);
      if (a_md) begin
        found = 1'b1;
        check_val("m5 idle at msg_done", 32'(a_busy), 32'd0);
        check_val("m5 en at msg_done",   32'(a_en),   32'd0);
        base2 = q0.size();
        set_coords(2, 4, 6, 8);
        break;
      end
    end
    check_val("m5 msg_done seen", 32'(found), 32'd1);
    @(negedge baud_clk);
    check_val("m6 accepted after msg_done", 32'(a_en), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      set_coords($urandom_range(0, 19), $urandom_range(0, 19),
                 $urandom_range(0, 19), $urandom_range(0, 19));
      @(negedge baud_clk);
      if (a_md) begin
        found = 1'b1;
        a_mv = 1'b0;
        break;
      end
    end
    a_mv = 1'b0;
    check_val("m6 msg_done seen", 32'(found), 32'd1);
    check_msg(0, base, base2, 72'h30_35_30_36_30_37_30_38_0A, 9, "m5");
    check_msg(0, base2, q0.size(), 72'h30_32_30_34_30_36_30_38_0A, 9, "m6");
    repeat (3) @(negedge baud_clk);
    check_val("m6 no third accept", 32'(a_busy), 32'd0);

    // Protocol monitors and pulse counts
    check_val("A en rise on done", 32'(viol_rise[0]), 32'd0);
    check_val("A tx_data stable",  32'(viol_hold[0]), 32'd0);
    check_val("A md and ce",       32'(viol_both[0]), 32'd0);
    check_val("B en rise on done", 32'(viol_rise[1]), 32'd0);
    check_val("B tx_data stable",  32'(viol_hold[1]), 32'd0);
    check_val("A msg_done pulses", 32'(md_cnt[0]), 32'd5);
    check_val("B msg_done pulses", 32'(md_cnt[1]), 32'd1);
    check_val("A coord_err pulses", 32'(ce_cnt[0]), 32'd1);

    // Reset mid-SEND: transmit_en must drop without a clock edge
    send_move(0, 9, 9, 9, 9);
    check_val("rs en before", 32'(a_en), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("rs en async drop", 32'(a_en), 32'd0);
    @(negedge baud_clk);
    reset = 1'b1;
    @(negedge baud_clk);
    check_val("rs move_ready", 32'(a_ready), 32'd1);
    check_val("rs busy",       32'(a_busy),  32'd0);
    check_val("rs tx_data",    32'(a_data),  32'h00);
    check_val("rs en after",   32'(a_en),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_msg_tx.md
Name: move_msg_tx

Overview:
- Upstream feeder for the UART byte transmitter.
- Accepts one connect-6 move (two stones, row/col each) from the game engine via valid/ready.
- Serialises the move into an ASCII message and drives the transmitter's tx_data_in/transmit_en/transmit_done_out handshake one byte at a time.
- Runs in the baud_clk domain, next to the transmitter.

Parameters:
- APPEND_NL, 1, when 1 a terminator byte follows the 8 digit bytes (message = 9 bytes); when 0 the message is 8 bytes.
- NL_CHAR, 8'h0A, terminator byte value.

Ports:
- baud_clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- move_valid  input  1  engine presents a move.
- move_ready  output  1  block can accept a move (high only in IDLE).
- row1  input  5  stone 1 row, legal 0..19.
- col1  input  5  stone 1 column, legal 0..19.
- row2  input  5  stone 2 row, legal 0..19.
- col2  input  5  stone 2 column, legal 0..19.
- tx_data  output  8  byte to the transmitter.
- transmit_en  output  1  request to the transmitter.
- transmit_done  input  1  transmitter's done flag.
- msg_done  output  1  one-cycle pulse after the last byte's handshake completes.
- coord_err  output  1  one-cycle pulse when a move is rejected.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, byte index=0, tx_data=8'h00, transmit_en=0, msg_done=0, coord_err=0, busy=0, move_ready=1.
  - Reset mid-message drops transmit_en immediately. The message is discarded, not resumed.
- Accept: on a posedge with move_valid=1 in IDLE, all four coordinates are checked.
  - Any value >19: move rejected. coord_err=1 for the following cycle, state stays IDLE, nothing transmitted.
  - All values ≤19: coordinates latched, index=0, state goes to SEND. Later input changes are ignored.
- Byte order: index 0..7 = row1 tens, row1 ones, col1 tens, col1 ones, row2 tens, row2 ones, col2 tens, col2 ones. Index 8 = NL_CHAR, only if APPEND_NL=1.
- Digit encoding:
  - tens = 1 if v≥10, else 0.
  - ones = v−10 if v≥10, else v.
  - byte = 8'h30 + digit.
  - Pure combinational compare/subtract on 5 bits; no divider.
- FSM states:
  - IDLE: move_ready=1, transmit_en=0.
  - SEND: transmit_en=1, tx_data=byte[index]. On transmit_done=1, go to RELEASE.
  - RELEASE: transmit_en=0, tx_data held. Wait for transmit_done=0.
    - If index is the last byte: msg_done=1 for one cycle, go to IDLE.
    - Otherwise: index+1, go to SEND.
- tx_data is stable for the whole time transmit_en is high and changes only on the RELEASE→SEND edge.
- transmit_en never rises while transmit_done=1. The transmitter's done flag must be observed low first.
- Latency: accept edge → transmit_en high on the next cycle. A move_valid held high during RELEASE of the final byte is accepted on the cycle after the return to IDLE, never earlier.
- transmit_done=1 arriving in IDLE or RELEASE before SEND has no effect beyond the RELEASE wait rule above.
- msg_done and coord_err are never high together.

Test Plan:
- Reset held low mid-SEND → transmit_en=0 immediately, even with no clock edge. After release: move_ready=1, busy=0, tx_data=8'h00.
- Move (3,15,10,19), APPEND_NL=1, with a transmitter model → bytes 30 33 31 35 31 30 31 39 0A in order, one msg_done pulse after the 9th handshake, busy low afterwards.
- APPEND_NL=0, move (0,0,19,9) → exactly 8 bytes: 30 30 30 30 31 39 30 39, then msg_done.
- Move (20,1,1,1) → coord_err pulse one cycle, transmit_en stays 0, move_ready stays 1. A subsequent valid move (1,1,1,1) is sent normally.
- Transmitter model holding transmit_done high 5 extra cycles after transmit_en falls → no new transmit_en until done low; tx_data unchanged throughout.
- move_valid held high continuously with changing coordinates → second move accepted only after msg_done. First message bytes unaffected by input changes during transmission.
